// File: rtl/prim_stack_if.sv
// Handshake/bus bundle for prim_stack: op request in, stack view and flags out.
interface prim_stack_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DSS   = 4
);
    logic             i_valid;
    logic [3:0]       i_op;
    logic [WIDTH-1:0] i_dat;
    logic             i_clr_err;
    logic [WIDTH-1:0] o_t;
    logic [WIDTH-1:0] o_n;
    logic [WIDTH-1:0] o_third;
    logic [DSS+1:0]   o_depth;
    logic             o_empty;
    logic             o_full;
    logic             o_ovf;
    logic             o_unf;

    modport master (
        output i_valid, i_op, i_dat, i_clr_err,
        input  o_t, o_n, o_third, o_depth, o_empty, o_full, o_ovf, o_unf
    );

    modport slave (
        input  i_valid, i_op, i_dat, i_clr_err,
        output o_t, o_n, o_third, o_depth, o_empty, o_full, o_ovf, o_unf
    );
endinterface

// File: rtl/prim_stack.sv
// prim_stack: data/return stack engine. T and N live in registers, deeper
// elements spill into a 2**DSS entry array addressed by sp (sp = array top).
// Capacity is 2**DSS + 2. Illegal ops are suppressed and flagged sticky.
// Optional PICK op (op 12) is built only when PRIM_STACK_PICK_EN is defined.
module prim_stack #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DSS   = 4
) (
    input logic        i_clk,
    input logic        i_reset,
    prim_stack_if.slave bus
);
    localparam int unsigned DW    = DSS + 2;
    localparam int unsigned CAP_I = (1 << DSS) + 2;
    localparam logic [DW-1:0]  CAP = DW'(CAP_I);
    localparam logic [DW-1:0]  D1  = DW'(1);
    localparam logic [DW-1:0]  D2  = DW'(2);
    localparam logic [DW-1:0]  D3  = DW'(3);
    localparam logic [DW-1:0]  D4  = DW'(4);
    localparam logic [DSS-1:0] SP1 = DSS'(1);
    localparam logic [DSS-1:0] SP2 = DSS'(2);

    typedef enum logic [3:0] {
        OP_NOP     = 4'd0,
        OP_PUSH    = 4'd1,
        OP_DROP    = 4'd2,
        OP_DUP     = 4'd3,
        OP_SWAP    = 4'd4,
        OP_OVER    = 4'd5,
        OP_NIP     = 4'd6,
        OP_ROT     = 4'd7,
        OP_NROT    = 4'd8,
        OP_REPLACE = 4'd9,
        OP_BINOP   = 4'd10,
        OP_DROP2   = 4'd11,
        OP_PICK    = 4'd12
    } op_e;

    logic [WIDTH-1:0] mem_q [(1 << DSS)];
    logic [WIDTH-1:0] t_q, t_d, n_q, n_d;
    logic [DSS-1:0]   sp_q, sp_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;

    logic             wr_en;
    logic [DSS-1:0]   wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             err_ovf, err_unf;
    logic             has1, has2, has3, has4, full;
    logic [WIDTH-1:0] third, below;
    op_e              op;

    assign op   = op_e'(bus.i_op);
    assign has1 = (depth_q >= D1);
    assign has2 = (depth_q >= D2);
    assign has3 = (depth_q >= D3);
    assign has4 = (depth_q >= D4);
    assign full = (depth_q == CAP);

    // Non-live array slots read as zero so T/N zero-fill falls out naturally.
    assign third = has3 ? mem_q[sp_q] : '0;
    assign below = has4 ? mem_q[sp_q - SP1] : '0;

`ifdef PRIM_STACK_PICK_EN
    logic [DW-1:0]    pick_k;
    logic [DSS-1:0]   pick_addr;
    logic [WIDTH-1:0] pick_data;

    assign pick_k    = bus.i_dat[DSS+1:0];
    assign pick_addr = sp_q - pick_k[DSS-1:0] + SP2;

    // Element k: 0 = T, 1 = N, otherwise array[sp-(k-2)].
    always_comb begin
        pick_data = mem_q[pick_addr];
        if (pick_k == '0)
            pick_data = t_q;
        else if (pick_k == D1)
            pick_data = n_q;
    end
`endif

    // Next-state decode: every op checks its depth/capacity guard first and
    // leaves all state untouched on error.
    always_comb begin
        t_d     = t_q;
        n_d     = n_q;
        sp_d    = sp_q;
        depth_d = depth_q;
        wr_en   = 1'b0;
        wr_addr = sp_q + SP1;
        wr_data = n_q;
        err_ovf = 1'b0;
        err_unf = 1'b0;
        if (bus.i_valid) begin
            case (op)
                OP_PUSH: begin
                    if (full) err_ovf = 1'b1;
                    else begin
                        t_d     = bus.i_dat;
                        n_d     = t_q;
                        depth_d = depth_q + D1;
                        if (has2) begin
                            wr_en = 1'b1;
                            sp_d  = sp_q + SP1;
                        end
                    end
                end
                OP_DROP: begin
                    if (!has1) err_unf = 1'b1;
                    else begin
                        t_d     = n_q;
                        n_d     = third;
                        depth_d = depth_q - D1;
                        if (has3) sp_d = sp_q - SP1;
                    end
                end
                OP_DUP: begin
                    if (!has1) err_unf = 1'b1;
                    else if (full) err_ovf = 1'b1;
                    else begin
                        n_d     = t_q;
                        depth_d = depth_q + D1;
                        if (has2) begin
                            wr_en = 1'b1;
                            sp_d  = sp_q + SP1;
                        end
                    end
                end
                OP_SWAP: begin
                    if (!has2) err_unf = 1'b1;
                    else begin
                        t_d = n_q;
                        n_d = t_q;
                    end
                end
                OP_OVER: begin
                    if (!has2) err_unf = 1'b1;
                    else if (full) err_ovf = 1'b1;
                    else begin
                        t_d     = n_q;
                        n_d     = t_q;
                        wr_en   = 1'b1;
                        sp_d    = sp_q + SP1;
                        depth_d = depth_q + D1;
                    end
                end
                OP_NIP: begin
                    if (!has2) err_unf = 1'b1;
                    else begin
                        n_d     = third;
                        depth_d = depth_q - D1;
                        if (has3) sp_d = sp_q - SP1;
                    end
                end
                OP_ROT: begin
                    if (!has3) err_unf = 1'b1;
                    else begin
                        t_d     = third;
                        n_d     = t_q;
                        wr_en   = 1'b1;
                        wr_addr = sp_q;
                        wr_data = n_q;
                    end
                end
                OP_NROT: begin
                    if (!has3) err_unf = 1'b1;
                    else begin
                        t_d     = n_q;
                        n_d     = third;
                        wr_en   = 1'b1;
                        wr_addr = sp_q;
                        wr_data = t_q;
                    end
                end
                OP_REPLACE: begin
                    if (!has1) err_unf = 1'b1;
                    else t_d = bus.i_dat;
                end
                OP_BINOP: begin
                    if (!has2) err_unf = 1'b1;
                    else begin
                        t_d     = bus.i_dat;
                        n_d     = third;
                        depth_d = depth_q - D1;
                        if (has3) sp_d = sp_q - SP1;
                    end
                end
                OP_DROP2: begin
                    if (!has2) err_unf = 1'b1;
                    else begin
                        t_d     = third;
                        n_d     = below;
                        depth_d = depth_q - D2;
                        // Only pop as many array entries as were actually live.
                        if (has4) sp_d = sp_q - SP2;
                        else if (has3) sp_d = sp_q - SP1;
                    end
                end
`ifdef PRIM_STACK_PICK_EN
                OP_PICK: begin
                    if (depth_q <= pick_k) err_unf = 1'b1;
                    else t_d = pick_data;
                end
`endif
                default: ;
            endcase
        end
        // A new error wins over a same-edge clear; the other flag still clears.
        ovf_d = err_ovf ? 1'b1 : (bus.i_clr_err ? 1'b0 : ovf_q);
        unf_d = err_unf ? 1'b1 : (bus.i_clr_err ? 1'b0 : unf_q);
    end

    // Register state with synchronous reset; reset overrides any valid op.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            t_q     <= '0;
            n_q     <= '0;
            sp_q    <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            t_q     <= t_d;
            n_q     <= n_d;
            sp_q    <= sp_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Spill array write port; contents survive reset by design.
    always_ff @(posedge i_clk) begin
        if (!i_reset && wr_en)
            mem_q[wr_addr] <= wr_data;
    end

    assign bus.o_t     = t_q;
    assign bus.o_n     = n_q;
    assign bus.o_third = third;
    assign bus.o_depth = depth_q;
    assign bus.o_empty = (depth_q == '0);
    assign bus.o_full  = full;
    assign bus.o_ovf   = ovf_q;
    assign bus.o_unf   = unf_q;
endmodule
